// File: rtl/shake_pkg.sv
// Shared SHAKE constants and the squeeze-phase state encoding.
// Rates are in bytes per Keccak block for each SHAKE variant.
package shake_pkg;

  localparam int unsigned RATE_SHAKE128_BYTES = 168;
  localparam int unsigned RATE_SHAKE256_BYTES = 136;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DUMP = 3'd1,
    PERMUTE   = 3'd2,
    DRAIN     = 3'd3,
    FINISH    = 3'd4
  } squeeze_state_t;

endpackage

// File: rtl/squeeze_scheduler.sv
// Squeeze-phase sequencer: hands rate-sized blocks to the dump stage, one per visit to WAIT_DUMP,
// overlapping each handoff with the next permutation; dump_available low stalls it indefinitely.
module squeeze_scheduler
  import shake_pkg::*;
#(
  parameter int LEN_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             shake256,
  input  logic [LEN_W-1:0] out_len,
  output logic             perm_start,
  input  logic             perm_done,
  input  logic             dump_available,
  output logic             dump_we,
  output logic             dump_last,
  output logic [CNT_W-1:0] dump_bytes,
  output logic             busy,
  output logic             done
);

  squeeze_state_t   state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0] rate, rate_nxt;
  logic [LEN_W-1:0] rate_ext;
  logic             last_blk;

  logic             perm_start_c;
  logic             dump_we_c;
  logic             dump_last_c;
  logic [CNT_W-1:0] dump_bytes_c;
  logic             done_c;

  assign rate_ext = LEN_W'(rate);
  assign last_blk = (remaining <= rate_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      rate      <= CNT_W'(RATE_SHAKE128_BYTES);
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      rate      <= rate_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    rate_nxt      = rate;
    perm_start_c  = 1'b0;
    dump_we_c     = 1'b0;
    dump_last_c   = 1'b0;
    dump_bytes_c  = '0;
    done_c        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (out_len != '0) begin
            remaining_nxt = out_len;
            rate_nxt      = shake256 ? CNT_W'(RATE_SHAKE256_BYTES)
                                     : CNT_W'(RATE_SHAKE128_BYTES);
            state_nxt     = WAIT_DUMP;
          end else begin
            state_nxt = FINISH;
          end
        end
      end

      WAIT_DUMP: begin
        if (dump_available) begin
          dump_we_c    = 1'b1;
          dump_last_c  = last_blk;
          dump_bytes_c = last_blk ? remaining[CNT_W-1:0] : rate;
          if (last_blk) begin
            state_nxt = DRAIN;
          end else begin
            // Only reached when remaining > rate, so no underflow.
            remaining_nxt = remaining - rate_ext;
            perm_start_c  = 1'b1;
            state_nxt     = PERMUTE;
          end
        end
      end

      PERMUTE: begin
        if (perm_done) state_nxt = WAIT_DUMP;
      end

      DRAIN: begin
        // dump_available drops while the dump stage writes out the final block.
        if (dump_available) state_nxt = FINISH;
      end

      FINISH: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Suppress every pulse while reset is held so nothing escapes in the reset cycle.
  assign perm_start = perm_start_c & ~rst;
  assign dump_we    = dump_we_c & ~rst;
  assign dump_last  = dump_last_c & ~rst;
  assign dump_bytes = rst ? '0 : dump_bytes_c;
  assign done       = done_c & ~rst;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_squeeze_scheduler.sv
// Directed bench for squeeze_scheduler: inputs change 1 time unit after the rising edge,
// outputs are checked 1 unit later; a negedge monitor counts pulses.
module tb_squeeze_scheduler;

  localparam int LEN_W = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             shake256;
  logic [LEN_W-1:0] out_len;
  logic             perm_start;
  logic             perm_done;
  logic             dump_available;
  logic             dump_we;
  logic             dump_last;
  logic [CNT_W-1:0] dump_bytes;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  int n_we = 0, n_ps = 0, n_done = 0;
  int s_we, s_ps, s_done;

  always #5 clk = ~clk;

  squeeze_scheduler #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .shake256       (shake256),
    .out_len        (out_len),
    .perm_start     (perm_start),
    .perm_done      (perm_done),
    .dump_available (dump_available),
    .dump_we        (dump_we),
    .dump_last      (dump_last),
    .dump_bytes     (dump_bytes),
    .busy           (busy),
    .done           (done)
  );

  always @(negedge clk) begin
    if (dump_we)    n_we   <= n_we + 1;
    if (perm_start) n_ps   <= n_ps + 1;
    if (done)       n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic snap();
    s_we   = n_we;
    s_ps   = n_ps;
    s_done = n_done;
  endtask

  // Checks the handoff outputs in one call.
  task automatic chk_blk(input string tag, input logic we, input logic last,
                         input logic [CNT_W-1:0] bytes, input logic ps);
    chk({tag, "_we"},    32'(dump_we),    32'(we));
    chk({tag, "_last"},  32'(dump_last),  32'(last));
    chk({tag, "_bytes"}, 32'(dump_bytes), 32'(bytes));
    chk({tag, "_ps"},    32'(perm_start), 32'(ps));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; shake256 = 1'b0; out_len = '0;
    perm_done = 1'b0; dump_available = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    settle();
    // Reset state.
    chk_blk("rst", 1'b0, 1'b0, 8'd0, 1'b0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // SHAKE128, 32 bytes: single partial final block.
    cyc(); snap();
    start = 1'b1; shake256 = 1'b0; out_len = 32; dump_available = 1'b1;
    settle();
    chk("t1_c0_busy", 32'(busy), 32'd0);
    cyc(); start = 1'b0; settle();
    chk_blk("t1_blk", 1'b1, 1'b1, 8'd32, 1'b0);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    cyc(); settle();
    chk("t1_c2_we", 32'(dump_we), 32'd0);
    chk("t1_c2_done", 32'(done), 32'd0);
    cyc(); settle();
    chk("t1_c3_done", 32'(done), 32'd1);
    chk("t1_c3_busy", 32'(busy), 32'd1);
    cyc(); settle();
    chk("t1_c4_busy", 32'(busy), 32'd0);
    chk("t1_c4_done", 32'(done), 32'd0);
    chk("t1_n_we", 32'(n_we - s_we), 32'd1);
    chk("t1_n_ps", 32'(n_ps - s_ps), 32'd0);

    // SHAKE256, 272 bytes: two full blocks, second hits remaining == rate.
    snap();
    start = 1'b1; shake256 = 1'b1; out_len = 272; dump_available = 1'b1;
    cyc(); start = 1'b0; settle();
    chk_blk("t2_b0", 1'b1, 1'b0, 8'd136, 1'b1);
    cyc(); settle();
    chk("t2_perm_we", 32'(dump_we), 32'd0);
    for (int i = 0; i < 23; i++) cyc();
    perm_done = 1'b1; settle();
    // perm_done together with dump_available in PERMUTE only transitions.
    chk("t2_pd_we", 32'(dump_we), 32'd0);
    cyc(); perm_done = 1'b0; settle();
    chk_blk("t2_b1", 1'b1, 1'b1, 8'd136, 1'b0);
    cyc(); settle();
    chk("t2_drain_done", 32'(done), 32'd0);
    cyc(); settle();
    chk("t2_done", 32'(done), 32'd1);
    cyc(); settle();
    chk("t2_n_we", 32'(n_we - s_we), 32'd2);
    chk("t2_n_ps", 32'(n_ps - s_ps), 32'd1);

    // SHAKE128, 169 bytes: 168 then a 1-byte tail.
    snap();
    start = 1'b1; shake256 = 1'b0; out_len = 169; dump_available = 1'b1;
    cyc(); start = 1'b0; settle();
    chk_blk("t3_b0", 1'b1, 1'b0, 8'd168, 1'b1);
    cyc(); perm_done = 1'b1; settle();
    chk("t3_pd_we", 32'(dump_we), 32'd0);
    cyc(); perm_done = 1'b0; settle();
    chk_blk("t3_b1", 1'b1, 1'b1, 8'd1, 1'b0);
    cyc(); cyc(); settle();
    chk("t3_done", 32'(done), 32'd1);
    cyc(); settle();
    chk("t3_n_ps", 32'(n_ps - s_ps), 32'd1);
    chk("t3_n_we", 32'(n_we - s_we), 32'd2);

    // Zero-length request: done at cycle 1, restart attempt while busy ignored.
    snap();
    start = 1'b1; out_len = 0;
    cyc(); settle();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    cyc(); start = 1'b0; settle();
    chk("t4_c2_busy", 32'(busy), 32'd0);
    chk("t4_c2_done", 32'(done), 32'd0);
    cyc(); settle();
    chk("t4_n_we", 32'(n_we - s_we), 32'd0);
    chk("t4_n_ps", 32'(n_ps - s_ps), 32'd0);
    chk("t4_n_done", 32'(n_done - s_done), 32'd1);

    // Stalls in WAIT_DUMP and DRAIN, with an ignored start mid-stall.
    snap();
    start = 1'b1; shake256 = 1'b0; out_len = 50; dump_available = 1'b0;
    cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin start = 1'b1; out_len = 7; end
      else start = 1'b0;
      cyc();
    end
    start = 1'b0;
    chk("t5_stall_we", 32'(n_we - s_we), 32'd0);
    dump_available = 1'b1; settle();
    chk_blk("t5_blk", 1'b1, 1'b1, 8'd50, 1'b0);
    cyc(); dump_available = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("t5_drain_done", 32'(n_done - s_done), 32'd0);
    chk("t5_drain_busy", 32'(busy), 32'd1);
    dump_available = 1'b1;
    cyc(); settle();
    chk("t5_done", 32'(done), 32'd1);
    cyc(); settle();
    chk("t5_n_we", 32'(n_we - s_we), 32'd1);

    // Reset in PERMUTE, stray perm_done, then a clean 100-byte run.
    start = 1'b1; shake256 = 1'b1; out_len = 300; dump_available = 1'b1;
    cyc(); start = 1'b0; settle();
    chk_blk("t6_b0", 1'b1, 1'b0, 8'd136, 1'b1);
    cyc(); rst = 1'b1; settle();
    chk("t6_rstcyc_we", 32'(dump_we), 32'd0);
    cyc(); rst = 1'b0; perm_done = 1'b1; settle();
    chk_blk("t6_after_rst", 1'b0, 1'b0, 8'd0, 1'b0);
    chk("t6_busy", 32'(busy), 32'd0);
    cyc(); perm_done = 1'b0; settle();
    chk("t6_stray_busy", 32'(busy), 32'd0);
    chk("t6_stray_we", 32'(dump_we), 32'd0);
    snap();
    start = 1'b1; shake256 = 1'b0; out_len = 100;
    cyc(); start = 1'b0; settle();
    chk_blk("t6_blk", 1'b1, 1'b1, 8'd100, 1'b0);
    cyc(); cyc(); settle();
    chk("t6_done", 32'(done), 32'd1);
    cyc(); settle();
    chk("t6_end_busy", 32'(busy), 32'd0);
    chk("t6_n_ps", 32'(n_ps - s_ps), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/squeeze_scheduler.md
# squeeze_scheduler

Sequences the SHAKE squeeze phase after absorption. It tracks how many output bytes remain and hands one rate-sized block at a time to the output dump stage. It starts a Keccak permutation between blocks and flags the final, possibly partial, block. It sits between the permutation core and the dump stage, and drives that stage's `output_buffer_we_in` / `last_output_block_in` and valid-byte count.

## Interface
Parameters:
- LEN_W, 32, width of the requested output length in bytes
- CNT_W, 8, width of the per-block byte count (must hold 168)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin squeezing; state already permuted after absorb
- shake256  in  1  mode select sampled with start: 1 = rate 136 B, 0 = rate 168 B
- out_len  in  LEN_W  requested output bytes, sampled with start
- perm_start  out  1  one-cycle pulse to start a permutation
- perm_done  in  1  one-cycle pulse, permutation finished
- dump_available  in  1  dump stage can accept a block (its `output_buffer_available_wr`)
- dump_we  out  1  block handoff pulse (to `output_buffer_we_in`)
- dump_last  out  1  handed-off block is final; valid only with dump_we
- dump_bytes  out  CNT_W  valid bytes in handed-off block; valid only with dump_we
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse, all output drained by the dump stage

## Operation
- Registers:
  - `remaining` (LEN_W), decremented as blocks are handed off.
  - `rate` (CNT_W), 168 or 136, latched at start.
  - FSM state.
- IDLE:
  - start with out_len != 0: latch registers, go to WAIT_DUMP.
  - start with out_len == 0: go to FINISH.
  - start outside IDLE is ignored.
- WAIT_DUMP: wait for dump_available. On dump_available (Mealy, same cycle):
  - Assert dump_we.
  - dump_last = (remaining <= rate).
  - dump_bytes = dump_last ? remaining[CNT_W-1:0] : rate.
  - If last: go to DRAIN.
  - Otherwise: remaining <= remaining - rate, assert perm_start in the same cycle, go to PERMUTE.
  - Permutation and dump overlap: the dump stage latches the block on dump_we.
- PERMUTE: on perm_done, go to WAIT_DUMP. perm_done in any other state is ignored.
- DRAIN:
  - dump_available is low while the dump stage writes.
  - On dump_available high, go to FINISH.
- FINISH: assert done for one cycle, go to IDLE.
- Arithmetic:
  - Unsigned only.
  - The subtraction executes only when remaining > rate, so it never underflows.
  - Block count = ceil(out_len / rate).
- Undefined encodings go to IDLE.

## Timing
- Reset values:
  - State IDLE; remaining 0; rate 168.
  - Outputs: perm_start 0, dump_we 0, dump_last 0, dump_bytes 0, busy 0, done 0.
- Outputs are zero whenever not asserted per the rules above.
- Reset in any state takes effect at the next edge and overrides all other events. No pulse is emitted in the reset cycle.
- Latencies:
  - start at cycle 0 → busy from cycle 1.
  - First dump_we no earlier than cycle 1.
  - perm_done at cycle n → next dump_we no earlier than n+1.
  - Last dump_we at cycle m → done no earlier than m+2.
  - out_len == 0: done at cycle 1, busy high only in cycle 1, no dump_we or perm_start.
- dump_we pulses at most once per WAIT_DUMP visit, whatever the dump_available duration.
- dump_available held low stalls indefinitely in WAIT_DUMP or DRAIN.
- perm_done coinciding with dump_available in PERMUTE: transition only. dump_we waits until WAIT_DUMP.

## Structure
- Shared package `shake_pkg`:
  - RATE_SHAKE128_BYTES = 168 and RATE_SHAKE256_BYTES = 136.
  - `squeeze_state_t` enum {IDLE, WAIT_DUMP, PERMUTE, DRAIN, FINISH}.
- Single flat module. No sub-module is warranted; the remaining-length counter stays inline.

## Test plan
- SHAKE128, out_len=32, dump_available=1 → one dump_we with dump_last=1, dump_bytes=32; no perm_start; done 2 cycles after release of dump_available.
- SHAKE256, out_len=272 → dump_we (136, last=0) with perm_start in the same cycle; perm_done after 24 cycles; dump_we (136, last=1); done after drain.
- SHAKE128, out_len=169 → blocks 168/last=0, then 1/last=1; exactly one perm_start.
- out_len=0 → done at cycle 1; no dump_we or perm_start; second start during busy ignored.
- Hold dump_available low 10 cycles in WAIT_DUMP and DRAIN → no dump_we or done during the stall; single dump_we on release.
- rst asserted mid-PERMUTE, then perm_done → all outputs 0, busy 0; stray perm_done ignored; a fresh start with out_len=100 completes normally.
